// File: rtl/serial_mux_mag_cmp.sv
// serial_mux_mag_cmp: multi-channel bit-serial unsigned magnitude comparator.
// Operand A comes from src_hi or src_lo of the selected channel and is compared
// MSB-first against threshold B, one bit per cycle. The result is held under
// a valid/ready handshake.
// Optional feature macro: CMP_HIT_CNT_EN adds a saturating hit_cnt output.
module serial_mux_mag_cmp #(
  parameter  int WIDTH      = 5,
  parameter  int NCH        = 4,
  parameter  int EARLY_EXIT = 1,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CYC_W      = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic                 mode,
  input  logic [NCH*WIDTH-1:0] src_hi,
  input  logic [NCH*WIDTH-1:0] src_lo,
  input  logic [WIDTH-1:0]     thr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 res_gt,
  output logic                 res_eq,
  output logic                 res_lt,
  output logic [CH_W-1:0]      res_ch,
`ifdef CMP_HIT_CNT_EN
  output logic [7:0]           hit_cnt,
`endif
  output logic [CYC_W-1:0]     res_cyc
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx;
  logic             diff_seen;
  logic             gt_seen;

  logic [WIDTH-1:0] a_sel;
  logic             bit_diff;
  logic             any_diff;
  logic             a_gt;
  logic             last_bit;

  // Operand select: channel 0 is the default, so out-of-range indices fall back to it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    a_sel = mode ? src_hi[WIDTH-1:0] : src_lo[WIDTH-1:0];
    for (int c = 1; c < NCH; c++) begin
      if (ch_sel == CH_W'(c)) begin
        a_sel = mode ? src_hi[c*WIDTH +: WIDTH] : src_lo[c*WIDTH +: WIDTH];
      end
    end
  end

  // Per-bit compare; the first recorded difference decides the result direction.
  always_comb begin
    bit_diff = a_reg[idx] ^ b_reg[idx];
    any_diff = diff_seen | bit_diff;
    a_gt     = diff_seen ? gt_seen : a_reg[idx];
    last_bit = (idx == '0) || ((EARLY_EXIT != 0) && bit_diff);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res_gt    <= 1'b0;
      res_eq    <= 1'b0;
      res_lt    <= 1'b0;
      res_ch    <= '0;
      res_cyc   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      diff_seen <= 1'b0;
      gt_seen   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a_sel;
            b_reg     <= thr;
            res_ch    <= ch_sel;
            idx       <= IDX_W'(WIDTH - 1);
            diff_seen <= 1'b0;
            gt_seen   <= 1'b0;
            res_cyc   <= '0;
            in_ready  <= 1'b0;
            state     <= CMP;
          end
        end
        CMP: begin
          res_cyc <= res_cyc + 1'b1;
          if (bit_diff && !diff_seen) begin
            diff_seen <= 1'b1;
            gt_seen   <= a_reg[idx];
          end
          if (last_bit) begin
            out_valid <= 1'b1;
            res_gt    <= any_diff & a_gt;
            res_lt    <= any_diff & ~a_gt;
            res_eq    <= ~any_diff;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
            res_lt    <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CMP_HIT_CNT_EN
  // Saturating count of consumed "greater" results; a consumed "less" result clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if ((state == DONE) && out_ready) begin
      if (res_lt) begin
        hit_cnt <= '0;
      end else if (res_gt && (hit_cnt != 8'hFF)) begin
        hit_cnt <= hit_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_mux_mag_cmp.sv
// Directed testbench for serial_mux_mag_cmp. Three instances: early-exit (a),
// full-length compare (b), and a 5-channel build for out-of-range selects (c).
// Hit-counter checks are compiled in when CMP_HIT_CNT_EN is defined.
module tb_serial_mux_mag_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [4:0]  thr;
  logic        out_ready;
  logic [19:0] hi4, lo4;
  logic [24:0] hi5, lo5;
  logic [1:0]  ch_a;
  logic [2:0]  ch_c;
  logic        iv_a, iv_b, iv_c;

  logic       ov_a, ir_a, gt_a, eq_a, lt_a;
  logic       ov_b, ir_b, gt_b, eq_b, lt_b;
  logic       ov_c, ir_c, gt_c, eq_c, lt_c;
  logic [1:0] rch_a, rch_b;
  logic [2:0] rch_c;
  logic [2:0] cyc_a, cyc_b, cyc_c;
`ifdef CMP_HIT_CNT_EN
  logic [7:0] hc_a, hc_b, hc_c;
`endif

  int checks = 0;
  int errors = 0;
  int cur    = 0;
  int lat;

  logic       o_valid, o_ready, o_gt, o_eq, o_lt;
  logic [2:0] o_ch, o_cyc;

  always #5 clk = ~clk;

  serial_mux_mag_cmp #(.WIDTH(5), .NCH(4), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .ch_sel(ch_a),
    .mode(mode), .src_hi(hi4), .src_lo(lo4), .thr(thr), .out_valid(ov_a),
    .out_ready(out_ready), .res_gt(gt_a), .res_eq(eq_a), .res_lt(lt_a),
    .res_ch(rch_a),
`ifdef CMP_HIT_CNT_EN
    .hit_cnt(hc_a),
`endif
    .res_cyc(cyc_a)
  );

  serial_mux_mag_cmp #(.WIDTH(5), .NCH(4), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .ch_sel(ch_a),
    .mode(mode), .src_hi(hi4), .src_lo(lo4), .thr(thr), .out_valid(ov_b),
    .out_ready(out_ready), .res_gt(gt_b), .res_eq(eq_b), .res_lt(lt_b),
    .res_ch(rch_b),
`ifdef CMP_HIT_CNT_EN
    .hit_cnt(hc_b),
`endif
    .res_cyc(cyc_b)
  );

  serial_mux_mag_cmp #(.WIDTH(5), .NCH(5), .EARLY_EXIT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .ch_sel(ch_c),
    .mode(mode), .src_hi(hi5), .src_lo(lo5), .thr(thr), .out_valid(ov_c),
    .out_ready(out_ready), .res_gt(gt_c), .res_eq(eq_c), .res_lt(lt_c),
    .res_ch(rch_c),
`ifdef CMP_HIT_CNT_EN
    .hit_cnt(hc_c),
`endif
    .res_cyc(cyc_c)
  );

  // Observation mux for the instance under test.
  always_comb begin
    o_valid = ov_a; o_ready = ir_a; o_gt = gt_a; o_eq = eq_a; o_lt = lt_a;
    o_ch = {1'b0, rch_a}; o_cyc = cyc_a;
    case (cur)
      1: begin
        o_valid = ov_b; o_ready = ir_b; o_gt = gt_b; o_eq = eq_b; o_lt = lt_b;
        o_ch = {1'b0, rch_b}; o_cyc = cyc_b;
      end
      2: begin
        o_valid = ov_c; o_ready = ir_c; o_gt = gt_c; o_eq = eq_c; o_lt = lt_c;
        o_ch = rch_c; o_cyc = cyc_c;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; return the edge count from accept to out_valid.
  task automatic issue(input int d, input int ch, input logic m, input logic [4:0] t,
                       output int l);
    @(negedge clk);
    cur  = d;
    mode = m;
    thr  = t;
    case (d)
      0:       begin ch_a = ch[1:0]; iv_a = 1'b1; end
      1:       begin ch_a = ch[1:0]; iv_b = 1'b1; end
      default: begin ch_c = ch[2:0]; iv_c = 1'b1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    l = 1;
    while (!o_valid && l < 20) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic expect_res(input string tag, input int l, input int exp_l, input logic g,
                            input logic e, input logic lt, input int cyc, input int ch);
    check({tag, "_lat"}, l, exp_l);
    check({tag, "_gt"}, o_gt, g);
    check({tag, "_eq"}, o_eq, e);
    check({tag, "_lt"}, o_lt, lt);
    check({tag, "_cyc"}, o_cyc, cyc);
    if (ch >= 0) check({tag, "_ch"}, o_ch, ch);
  endtask

  // Handshake the pending result; in_ready must be back the cycle after.
  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ready_after"}, o_ready, 1);
    check({tag, "_valid_low"}, o_valid, 0);
    check({tag, "_flags_low"}, {o_gt, o_eq, o_lt}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; thr = '0; out_ready = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0; ch_a = '0; ch_c = '0;
    hi4 = '0; lo4 = '0; hi5 = '0; lo5 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", ir_a, 1);
    check("rst_valid", ov_a, 0);
    check("rst_flags", {gt_a, eq_a, lt_a}, 0);
    check("rst_ch", rch_a, 0);
    check("rst_cyc", cyc_a, 0);
    rst_n = 1'b1;

    // Reset asserted mid-compare with in_valid held high
    lo4[9:5] = 5'd19;
    @(negedge clk);
    cur = 0; mode = 1'b0; thr = 5'd19; ch_a = 2'd1; iv_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", ir_a, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov_a, 0);
    check("mid_rst_ready", ir_a, 1);
    check("mid_rst_flags", {gt_a, eq_a, lt_a}, 0);
    check("mid_rst_cyc", cyc_a, 0);
    @(negedge clk);
    iv_a = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_no_result", ov_a, 0);
    check("mid_idle_ready", ir_a, 1);

    // Early exit at the MSB: 10110 vs 01111
    hi4[14:10] = 5'b10110;
    issue(0, 2, 1'b1, 5'b01111, lat);
    expect_res("gt_msb", lat, 2, 1, 0, 0, 1, 2);
    pop("gt_msb");

    // Equal operands run the full width
    issue(0, 1, 1'b0, 5'd19, lat);
    expect_res("eq19", lat, 6, 0, 1, 0, 5, 1);
    pop("eq19");

    // Early exit at bit 2: 01100 vs 01010 and 00011 vs 00100
    lo4[4:0] = 5'b01100;
    issue(0, 0, 1'b0, 5'b01010, lat);
    expect_res("gt_mid", lat, 4, 1, 0, 0, 3, 0);
    pop("gt_mid");
    lo4[4:0] = 5'b00011;
    issue(0, 0, 1'b0, 5'b00100, lat);
    expect_res("lt_mid", lat, 4, 0, 0, 1, 3, 0);
    pop("lt_mid");

    // Full-length compare: LSB difference, then MSB-only difference
    lo4[19:15] = 5'b00001;
    issue(1, 3, 1'b0, 5'b00000, lat);
    expect_res("nx_gt_lsb", lat, 6, 1, 0, 0, 5, 3);
    pop("nx_gt_lsb");
    lo4[19:15] = 5'b00000;
    issue(1, 3, 1'b0, 5'b10000, lat);
    expect_res("nx_lt_msb", lat, 6, 0, 0, 1, 5, 3);
    pop("nx_lt_msb");
    // First difference wins even though later bits favour B
    lo4[19:15] = 5'b10000;
    issue(1, 3, 1'b0, 5'b01111, lat);
    expect_res("nx_first_diff", lat, 6, 1, 0, 0, 5, 3);
    pop("nx_first_diff");

    // Back-pressure: 00011 vs 01000 held for 10 cycles while new requests are offered
    hi4[4:0] = 5'd3;
    issue(0, 0, 1'b1, 5'd8, lat);
    expect_res("bp", lat, 3, 0, 0, 1, 2, 0);
    for (int i = 0; i < 10; i++) begin
      iv_a = 1'b1; thr = 5'd0; ch_a = 2'd2;
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_ready", o_ready, 0);
      check("bp_hold_flags", {o_gt, o_eq, o_lt}, 3'b001);
      check("bp_hold_cyc", o_cyc, 2);
    end
    iv_a = 1'b0;
    pop("bp");
    repeat (3) @(negedge clk);
    check("bp_no_ghost", o_valid, 0);

    // Out-of-range channel select on a 5-channel build falls back to channel 0
    lo5 = {5'd5, 5'd5, 5'd5, 5'd5, 5'd20};
    issue(2, 7, 1'b0, 5'd10, lat);
    expect_res("oor_ch7", lat, 2, 1, 0, 0, 1, -1);
    pop("oor_ch7");
    issue(2, 4, 1'b0, 5'd10, lat);
    expect_res("ch4", lat, 3, 0, 0, 1, 2, 4);
    pop("ch4");

`ifdef CMP_HIT_CNT_EN
    // Hit counter: saturation, hold on equal, clear on less-than
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("hit_rst", hc_a, 0);
    for (int i = 0; i < 300; i++) begin
      issue(0, 2, 1'b1, 5'b01111, lat);
      pop("hit_gt");
      if (i == 0)   check("hit_first", hc_a, 1);
      if (i == 254) check("hit_255", hc_a, 255);
    end
    check("hit_sat", hc_a, 255);
    issue(0, 1, 1'b0, 5'd19, lat);
    pop("hit_eq");
    check("hit_eq_hold", hc_a, 255);
    issue(0, 0, 1'b1, 5'd8, lat);
    pop("hit_lt");
    check("hit_lt_clear", hc_a, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
